// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection, PC enable sequencing and fetch handshake
// Optional PC_SEQ_PERF_EN builds saturating stall/redirect counters.
module pc_sequencer #(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter logic [W-1:0] INC       = W'(4)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] PCF,
  input  logic         StallF,
  input  logic         BranchTakenD,
  input  logic [W-1:0] BranchTargetD,
  input  logic         JumpD,
  input  logic [W-1:0] JumpTargetD,
  input  logic         IMemAck,
  output logic         IMemReq,
  output logic [W-1:0] PCNext,
  output logic         EN,
  output logic         FlushD,
  output logic [31:0]  StallCnt,
  output logic [31:0]  RedirCnt
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_v_q, pend_v_d;

  logic         redirect;
  logic [W-1:0] redir_tgt;
  logic [W-1:0] sel_pc;
  logic         advance;

  always_comb begin
    redirect  = JumpD | BranchTakenD;
    redir_tgt = JumpD ? JumpTargetD : BranchTargetD;
    if (redirect)      sel_pc = redir_tgt;
    else if (pend_v_q) sel_pc = pend_q;
    else               sel_pc = PCF + INC;

    advance = (state_q == BOOT) ||
              (state_q == FETCH && IMemAck && !StallF) ||
              (state_q == HOLD && !StallF);

    IMemReq  = 1'b0;
    EN       = 1'b1;
    PCNext   = PCF;
    FlushD   = 1'b0;
    state_d  = state_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (RST) begin
      PCNext = RESET_VEC;
    end else begin
      case (state_q)
        BOOT: begin
          EN      = 1'b0;
          PCNext  = RESET_VEC;
          FlushD  = 1'b1;
          state_d = FETCH;
        end
        FETCH: begin
          IMemReq = 1'b1;
          if (advance) begin
            EN     = 1'b0;
            PCNext = sel_pc;
          end else if (IMemAck && StallF) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!StallF) begin
            EN      = 1'b0;
            PCNext  = sel_pc;
            state_d = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase

      if (redirect) FlushD = 1'b1;

      // A redirect that cannot be taken now is parked until fetch advances.
      if (advance) begin
        pend_v_d = 1'b0;
      end else if (redirect) begin
        pend_d   = redir_tgt;
        pend_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= BOOT;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (state_q != BOOT && EN && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect && redir_cnt_q != 32'hFFFF_FFFF)
      redir_cnt_d = redir_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign RedirCnt = redir_cnt_q;
`else
  assign StallCnt = '0;
  assign RedirCnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector table plus randomized run against a behavioural model
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PCF;
  logic        StallF;
  logic        BranchTakenD;
  logic [31:0] BranchTargetD;
  logic        JumpD;
  logic [31:0] JumpTargetD;
  logic        IMemAck;
  logic        IMemReq;
  logic [31:0] PCNext;
  logic        EN;
  logic        FlushD;
  logic [31:0] StallCnt;
  logic [31:0] RedirCnt;

  always #5 CLK = ~CLK;

  pc_sequencer #(.W(32), .RESET_VEC(32'h0), .INC(32'h4)) dut (
    .CLK(CLK), .RST(RST), .PCF(PCF), .StallF(StallF),
    .BranchTakenD(BranchTakenD), .BranchTargetD(BranchTargetD),
    .JumpD(JumpD), .JumpTargetD(JumpTargetD), .IMemAck(IMemAck),
    .IMemReq(IMemReq), .PCNext(PCNext), .EN(EN), .FlushD(FlushD),
    .StallCnt(StallCnt), .RedirCnt(RedirCnt)
  );

  typedef struct {
    logic rst, stall, ack;
    logic [31:0] pcf;
    logic jd;
    logic [31:0] jt;
    logic br;
    logic [31:0] bt;
    logic req, en;
    logic [31:0] pcn;
    logic flush;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  // Model: fetch is either booting, waiting on memory, or holding returned data for a stall release.
  bit          m_init = 0;
  bit          m_boot = 0;
  bit          m_have = 0;
  logic [31:0] m_pend[$];
  logic [31:0] m_stall = 0, m_redir = 0;
  logic        m_req, m_en, m_flush, m_move;
  logic [31:0] m_pcn;

  task automatic row(input logic rst, stall, ack, input logic [31:0] pcf,
                     input logic jd, input logic [31:0] jt, input logic br, input logic [31:0] bt,
                     input logic req, en, input logic [31:0] pcn, input logic flush);
    vec_t v;
    v.rst = rst; v.stall = stall; v.ack = ack; v.pcf = pcf;
    v.jd = jd; v.jt = jt; v.br = br; v.bt = bt;
    v.req = req; v.en = en; v.pcn = pcn; v.flush = flush;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %h, expected %h", nm, n_vec, act, exp);
    end
  endtask

  task automatic drive(input logic rst, stall, ack, input logic [31:0] pcf,
                       input logic jd, input logic [31:0] jt, input logic br, input logic [31:0] bt);
    @(negedge CLK);
    RST = rst; StallF = stall; IMemAck = ack; PCF = pcf;
    JumpD = jd; JumpTargetD = jt; BranchTakenD = br; BranchTargetD = bt;
    #2;
  endtask

  task automatic model_eval();
    logic [31:0] nat;
    nat = (m_pend.size() > 0) ? m_pend[0] : PCF + 32'd4;
    m_move = 1'b0;
    if (RST) begin
      m_req = 0; m_en = 1; m_flush = 0; m_pcn = 32'h0;
    end else if (m_boot) begin
      m_req = 0; m_en = 0; m_flush = 1; m_pcn = 32'h0; m_move = 1'b1;
    end else begin
      m_req   = !m_have;
      m_move  = m_have ? !StallF : (IMemAck && !StallF);
      m_en    = !m_move;
      m_flush = JumpD | BranchTakenD;
      m_pcn   = !m_move ? PCF : JumpD ? JumpTargetD : BranchTakenD ? BranchTargetD : nat;
    end
  endtask

  task automatic model_update();
    logic redirect;
    redirect = JumpD | BranchTakenD;
    if (RST) begin
      m_init = 1; m_boot = 1; m_have = 0; m_pend.delete(); m_stall = 0; m_redir = 0;
    end else begin
      if (!m_boot && m_en && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (redirect && m_redir != 32'hFFFF_FFFF) m_redir++;
      if (m_boot) begin
        m_boot = 0; m_have = 0; m_pend.delete();
      end else if (m_move) begin
        m_have = 0; m_pend.delete();
      end else begin
        if (!m_have && IMemAck && StallF) m_have = 1;
        if (redirect) begin
          m_pend.delete();
          m_pend.push_back(JumpD ? JumpTargetD : BranchTargetD);
        end
      end
    end
  endtask

  task automatic chk_counters();
    if (m_init) begin
`ifdef PC_SEQ_PERF_EN
      chk("StallCnt", StallCnt, m_stall);
      chk("RedirCnt", RedirCnt, m_redir);
`else
      chk("StallCnt", StallCnt, 32'h0);
      chk("RedirCnt", RedirCnt, 32'h0);
`endif
    end
  endtask

  initial begin
    logic [31:0] pc_reg;
    RST = 1; StallF = 0; IMemAck = 0; PCF = 0;
    JumpD = 0; JumpTargetD = 0; BranchTakenD = 0; BranchTargetD = 0;

    //   rst st ack pcf            jd jt         br bt          req en pcn          fl
    for (int i = 0; i < 3; i++)
      row(1, 0, 1, 32'h0,          0, 32'h0,     0, 32'h0,      0, 1, 32'h0,        0);
    row(0, 0, 1, 32'h0,            0, 32'h0,     0, 32'h0,      0, 0, 32'h0,        1);
    row(0, 0, 1, 32'h0,            0, 32'h0,     0, 32'h0,      1, 0, 32'h4,        0);
    row(0, 0, 1, 32'h4,            0, 32'h0,     0, 32'h0,      1, 0, 32'h8,        0);
    row(0, 0, 1, 32'h8,            0, 32'h0,     0, 32'h0,      1, 0, 32'hC,        0);
    row(0, 0, 0, 32'h10,           0, 32'h0,     0, 32'h0,      1, 1, 32'h10,       0);
    row(0, 0, 0, 32'h10,           0, 32'h0,     0, 32'h0,      1, 1, 32'h10,       0);
    row(0, 0, 1, 32'h10,           0, 32'h0,     0, 32'h0,      1, 0, 32'h14,       0);
    row(0, 1, 1, 32'h20,           0, 32'h0,     0, 32'h0,      1, 1, 32'h20,       0);
    row(0, 1, 1, 32'h20,           1, 32'h80,    0, 32'h0,      0, 1, 32'h20,       1);
    row(0, 1, 1, 32'h20,           0, 32'h0,     0, 32'h0,      0, 1, 32'h20,       0);
    row(0, 0, 0, 32'h20,           0, 32'h0,     0, 32'h0,      0, 0, 32'h80,       0);
    row(0, 0, 1, 32'h80,           0, 32'h0,     0, 32'h0,      1, 0, 32'h84,       0);
    row(0, 0, 0, 32'h84,           0, 32'h0,     1, 32'h300,    1, 1, 32'h84,       1);
    row(0, 0, 1, 32'h84,           1, 32'h100,   1, 32'h200,    1, 0, 32'h100,      1);
    row(0, 0, 1, 32'h100,          0, 32'h0,     0, 32'h0,      1, 0, 32'h104,      0);
    row(0, 0, 1, 32'hFFFF_FFFC,    0, 32'h0,     0, 32'h0,      1, 0, 32'h0,        0);
    row(0, 0, 1, 32'h0,            0, 32'h0,     1, 32'h200,    1, 0, 32'h200,      1);
    row(0, 0, 0, 32'h200,          0, 32'h0,     1, 32'h300,    1, 1, 32'h200,      1);
    row(0, 0, 0, 32'h200,          1, 32'h500,   0, 32'h0,      1, 1, 32'h200,      1);
    row(0, 0, 1, 32'h200,          0, 32'h0,     0, 32'h0,      1, 0, 32'h500,      0);
    row(0, 1, 1, 32'h500,          0, 32'h0,     0, 32'h0,      1, 1, 32'h500,      0);
    row(0, 1, 1, 32'h500,          1, 32'h400,   0, 32'h0,      0, 1, 32'h500,      1);
    row(1, 1, 0, 32'h500,          0, 32'h0,     0, 32'h0,      0, 1, 32'h0,        0);
    row(0, 0, 1, 32'h500,          0, 32'h0,     0, 32'h0,      0, 0, 32'h0,        1);
    row(0, 0, 1, 32'h0,            0, 32'h0,     0, 32'h0,      1, 0, 32'h4,        0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].ack, tbl[i].pcf,
            tbl[i].jd, tbl[i].jt, tbl[i].br, tbl[i].bt);
      chk("IMemReq", {31'b0, IMemReq}, {31'b0, tbl[i].req});
      chk("EN",      {31'b0, EN},      {31'b0, tbl[i].en});
      chk("PCNext",  PCNext,           tbl[i].pcn);
      chk("FlushD",  {31'b0, FlushD},  {31'b0, tbl[i].flush});
      model_eval();
      chk_counters();
      model_update();
      n_vec++;
    end

    pc_reg = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      logic rst, jd, br;
      logic [31:0] jt, bt;
      rst = (c < 2) || ($urandom_range(0, 59) == 0);
      jd  = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 5) == 0);
      jt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} >> 2 << 2;
      bt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom() & 32'hFFFF_FFFC;
      drive(rst, $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, pc_reg, jd, jt, br, bt);
      model_eval();
      chk("rand IMemReq", {31'b0, IMemReq}, {31'b0, m_req});
      chk("rand EN",      {31'b0, EN},      {31'b0, m_en});
      chk("rand PCNext",  PCNext,           m_pcn);
      chk("rand FlushD",  {31'b0, FlushD},  {31'b0, m_flush});
      chk_counters();
      if (!RST && !m_en) pc_reg = m_pcn;
      model_update();
      n_vec++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
